// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer/flag controller that turns an external 2**AW x DW register file
// into a synchronous FIFO with valid/ready handshakes on both sides.
// Ports:
//   clk, reset (sync, active-low), flush (sync, active-high)
//   in_valid/in_ready/in_data    : producer side
//   out_valid/out_ready/out_data : consumer side (out_data = rf_d_out, same-cycle read)
//   rf_wr/rf_wr_addr/rf_d_in     : register file write port
//   rf_rd_addr/rf_d_out          : register file combinational read port
//   count, almost_full           : registered occupancy and threshold flag
module fifo_ctrl #(
    parameter int unsigned DW        = 64,
    parameter int unsigned DEPTH     = 32,
    parameter int unsigned AW        = 5,
    parameter int unsigned AF_THRESH = 28
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          rf_wr,
    output logic [AW-1:0] rf_wr_addr,
    output logic [DW-1:0] rf_d_in,
    output logic [AW-1:0] rf_rd_addr,
    input  logic [DW-1:0] rf_d_out,
    output logic [AW:0]   count,
    output logic          almost_full
);

    localparam int unsigned PW = AW + 1;

    localparam logic [1:0] ST_EMPTY   = 2'd0;
    localparam logic [1:0] ST_PARTIAL = 2'd1;
    localparam logic [1:0] ST_FULL    = 2'd2;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] count_q, count_d;
    logic          almost_full_q, almost_full_d;
    logic [1:0]    state_q, state_d;

    logic empty;
    logic full;
    logic push;
    logic pop;

    // Pointer-derived flags: the MSB is the wrap bit distinguishing full from empty.
    always_comb begin
        empty = (wr_ptr_q == rd_ptr_q);
        full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    end

    // Handshakes and register file drive; reset and flush block both sides.
    always_comb begin
        in_ready   = !full && reset && !flush;
        out_valid  = !empty && reset && !flush;
        push       = in_valid && in_ready;
        pop        = out_valid && out_ready;
        rf_wr      = push;
        rf_wr_addr = wr_ptr_q[AW-1:0];
        rf_d_in    = in_data;
        rf_rd_addr = rd_ptr_q[AW-1:0];
        out_data   = rf_d_out;
    end

    // Next-state: pointers, occupancy, threshold flag and occupancy state.
    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        state_d       = state_q;
        almost_full_d = almost_full_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        if (push && !pop) begin
            count_d = count_q + PW'(1);
        end else if (pop && !push) begin
            count_d = count_q - PW'(1);
        end

        case (state_q)
            ST_EMPTY: begin
                if (push) begin
                    state_d = ST_PARTIAL;
                end
            end
            ST_PARTIAL: begin
                if (push && !pop && (count_q == PW'(DEPTH - 1))) begin
                    state_d = ST_FULL;
                end else if (pop && !push && (count_q == PW'(1))) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (pop && !push) begin
                    state_d = ST_PARTIAL;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase

        almost_full_d = (count_d >= PW'(AF_THRESH));

        // Reset and flush share one clear; queued words in the register file are abandoned.
        if (!reset || flush) begin
            wr_ptr_d      = '0;
            rd_ptr_d      = '0;
            count_d       = '0;
            state_d       = ST_EMPTY;
            almost_full_d = 1'b0;
        end
    end

    // State register; clearing is folded into the next-state logic above.
    always_ff @(posedge clk) begin
        wr_ptr_q      <= wr_ptr_d;
        rd_ptr_q      <= rd_ptr_d;
        count_q       <= count_d;
        state_q       <= state_d;
        almost_full_q <= almost_full_d;
    end

    always_comb begin
        count       = count_q;
        almost_full = almost_full_q;
    end

endmodule
